// File: rtl/nn_host_sequencer.sv
// Host-side master for the accelerator external bus: loads an input vector with the
// accelerator held in reset, runs it, then drains result words to an output stream.
module nn_host_sequencer #(
  parameter int LOAD_BASE      = 20,
  parameter int MAX_IN         = 20,
  parameter int RD_LAT         = 1,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  output logic       out_last,
  input  logic       out_ready,
  output logic       accel_reset,
  output logic [7:0] nr_write_adr,
  output logic [7:0] nr_write_data,
  output logic       nr_wr_en,
  output logic [7:0] nr_read_adr,
  input  logic [7:0] nr_read_data,
  input  logic       accel_finished,
  input  logic [7:0] result_base,
  input  logic [7:0] result_count,
  output logic       busy,
  output logic       done,
  output logic       err_overflow,
  output logic       err_timeout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FLUSH,
    S_RUN,
    S_DRAIN_RD,
    S_DRAIN_WAIT,
    S_DRAIN_OUT,
    S_DONE
  } state_t;

  localparam int KW = $clog2(MAX_IN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int LW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  localparam logic [7:0]    LB     = 8'(LOAD_BASE);
  localparam logic [KW-1:0] K_MAX  = KW'(MAX_IN);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [LW-1:0] L_LAST = LW'(RD_LAT - 1);

  state_t        state;
  state_t        state_nxt;
  logic [KW-1:0] wr_cnt;
  logic [TW-1:0] run_cnt;
  logic [LW-1:0] lat_cnt;
  logic [7:0]    idx;
  logic [7:0]    snap_base;
  logic [7:0]    snap_cnt;
  logic          accept;

  // in_ready is gated by reset so the stream sees no acceptance while reset is held.
  assign in_ready    = !reset && ((state == S_IDLE) || (state == S_LOAD));
  assign accept      = in_valid && in_ready;
  assign accel_reset = (state == S_IDLE) || (state == S_LOAD) ||
                       (state == S_FLUSH) || (state == S_DONE);
  assign busy        = (state != S_IDLE);
  assign done        = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) state_nxt = in_last ? S_FLUSH : S_LOAD;
      end
      S_LOAD: begin
        if (accept && in_last) state_nxt = S_FLUSH;
      end
      S_FLUSH: state_nxt = S_RUN;
      S_RUN: begin
        if (accel_finished)
          state_nxt = (result_count == 8'd0) ? S_DONE : S_DRAIN_RD;
        else if (run_cnt == T_LAST)
          state_nxt = S_DONE;
      end
      S_DRAIN_RD: state_nxt = S_DRAIN_WAIT;
      S_DRAIN_WAIT: begin
        if (lat_cnt == L_LAST) state_nxt = S_DRAIN_OUT;
      end
      S_DRAIN_OUT: begin
        if (out_ready) state_nxt = out_last ? S_DONE : S_DRAIN_RD;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_cnt        <= '0;
      run_cnt       <= '0;
      lat_cnt       <= '0;
      idx           <= 8'd0;
      snap_base     <= 8'd0;
      snap_cnt      <= 8'd0;
      nr_wr_en      <= 1'b0;
      nr_write_adr  <= 8'd0;
      nr_write_data <= 8'd0;
      nr_read_adr   <= 8'd0;
      out_data      <= 8'd0;
      out_valid     <= 1'b0;
      out_last      <= 1'b0;
      err_overflow  <= 1'b0;
      err_timeout   <= 1'b0;
    end else begin
      nr_wr_en <= 1'b0;

      if (accept) begin
        if (state == S_IDLE) begin
          err_overflow  <= 1'b0;
          err_timeout   <= 1'b0;
          nr_wr_en      <= 1'b1;
          nr_write_adr  <= LB;
          nr_write_data <= in_data;
          wr_cnt        <= KW'(1);
        end else if (wr_cnt < K_MAX) begin
          nr_wr_en      <= 1'b1;
          nr_write_adr  <= LB + 8'(wr_cnt);
          nr_write_data <= in_data;
          wr_cnt        <= wr_cnt + KW'(1);
        end else begin
          err_overflow <= 1'b1;
        end
      end

      case (state)
        S_FLUSH: run_cnt <= '0;
        S_RUN: begin
          // The result window is frozen here; the accelerator may change it afterwards.
          if (accel_finished) begin
            snap_base <= result_base;
            snap_cnt  <= result_count;
            idx       <= 8'd0;
          end else if (run_cnt == T_LAST) begin
            err_timeout <= 1'b1;
          end else begin
            run_cnt <= run_cnt + TW'(1);
          end
        end
        S_DRAIN_RD: begin
          nr_read_adr <= snap_base + idx;
          lat_cnt     <= '0;
        end
        S_DRAIN_WAIT: begin
          if (lat_cnt == L_LAST) begin
            out_data  <= nr_read_data;
            out_valid <= 1'b1;
            out_last  <= (idx == snap_cnt - 8'd1);
          end else begin
            lat_cnt <= lat_cnt + LW'(1);
          end
        end
        S_DRAIN_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            if (!out_last) idx <= idx + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nn_host_sequencer.sv
// Directed bench for nn_host_sequencer: vector table of whole jobs plus stall and reset sequences.
module tb_nn_host_sequencer;

  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] in_data = 8'd0;
  logic       in_valid = 1'b0;
  logic       in_last = 1'b0;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_last;
  logic       out_ready = 1'b1;
  logic       accel_reset;
  logic [7:0] nr_write_adr;
  logic [7:0] nr_write_data;
  logic       nr_wr_en;
  logic [7:0] nr_read_adr;
  logic [7:0] nr_read_data;
  logic       accel_finished = 1'b0;
  logic [7:0] result_base = 8'hEE;
  logic [7:0] result_count = 8'h77;
  logic       busy;
  logic       done;
  logic       err_overflow;
  logic       err_timeout;

  always #5 clk = ~clk;

  nn_host_sequencer #(
    .LOAD_BASE(20), .MAX_IN(20), .RD_LAT(1), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
    .accel_reset(accel_reset),
    .nr_write_adr(nr_write_adr), .nr_write_data(nr_write_data), .nr_wr_en(nr_wr_en),
    .nr_read_adr(nr_read_adr), .nr_read_data(nr_read_data),
    .accel_finished(accel_finished), .result_base(result_base), .result_count(result_count),
    .busy(busy), .done(done), .err_overflow(err_overflow), .err_timeout(err_timeout)
  );

  // Result RAM contents: two fixed words at 0/1, a simple pattern elsewhere.
  function automatic logic [7:0] ram_val(input logic [7:0] a);
    if (a == 8'd0) return 8'h11;
    if (a == 8'd1) return 8'h22;
    return a ^ 8'hA5;
  endfunction

  logic [7:0] ram [256];
  assign nr_read_data = ram[nr_read_adr];

  logic [7:0] wr_adr_q[$];
  logic [7:0] wr_dat_q[$];
  bit         wr_rst_q[$];
  logic [7:0] out_q[$];
  bit         outl_q[$];
  int         done_tot = 0;
  int         run_tot = 0;

  always @(posedge clk) begin
    if (nr_wr_en) begin
      wr_adr_q.push_back(nr_write_adr);
      wr_dat_q.push_back(nr_write_data);
      wr_rst_q.push_back(accel_reset);
    end
    if (out_valid && out_ready) begin
      out_q.push_back(out_data);
      outl_q.push_back(out_last);
    end
    if (done) done_tot <= done_tot + 1;
    if (!accel_reset) run_tot <= run_tot + 1;
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic check_reset_vals(input string p);
    check({p, "_accel_reset"}, accel_reset, 1);
    check({p, "_in_ready"}, in_ready, 0);
    check({p, "_wr_en"}, nr_wr_en, 0);
    check({p, "_wr_adr"}, nr_write_adr, 0);
    check({p, "_wr_dat"}, nr_write_data, 0);
    check({p, "_rd_adr"}, nr_read_adr, 0);
    check({p, "_out_valid"}, out_valid, 0);
    check({p, "_out_last"}, out_last, 0);
    check({p, "_out_data"}, out_data, 0);
    check({p, "_busy"}, busy, 0);
    check({p, "_done"}, done, 0);
    check({p, "_err_ovf"}, err_overflow, 0);
    check({p, "_err_to"}, err_timeout, 0);
  endtask

  task automatic load_words(input int n);
    @(posedge clk); #1;
    for (int j = 0; j < n; j++) begin
      int k;
      in_valid = 1'b1;
      in_data  = 8'(5 + j);
      in_last  = (j == n - 1);
      k = 0;
      @(negedge clk);
      while (!in_ready && k < 50) begin @(negedge clk); k++; end
      if (k >= 50) begin
        check("in_accept_wait", 0, 1);
        in_valid = 1'b0;
        in_last  = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // delay < 0: accelerator never finishes.
  task automatic start_accel(input int delay, input int base, input int cnt);
    int k;
    k = 0;
    if (delay < 0) return;
    while (accel_reset && k < 50) begin @(negedge clk); k++; end
    if (k >= 50) begin
      check("run_entry_wait", 0, 1);
      return;
    end
    repeat (delay) @(posedge clk);
    if (delay > 0) #1;
    result_base    = 8'(base);
    result_count   = 8'(cnt);
    accel_finished = 1'b1;
    @(posedge clk); #1;
    result_base  = 8'hEE;
    result_count = 8'h77;
  endtask

  task automatic wait_done(input string p, input int eo, input int et);
    int k;
    k = 0;
    @(negedge clk);
    while (!done && k < 300) begin @(negedge clk); k++; end
    accel_finished = 1'b0;
    if (k >= 300) begin
      check({p, "_done_wait"}, 0, 1);
      return;
    end
    check({p, "_err_ovf"}, err_overflow, eo);
    check({p, "_err_to"}, err_timeout, et);
    check({p, "_done_rst"}, accel_reset, 1);
    @(negedge clk);
    check({p, "_done_pulse"}, done, 0);
    check({p, "_idle_busy"}, busy, 0);
    check({p, "_idle_rst"}, accel_reset, 1);
  endtask

  typedef struct {
    int n_in;
    int base;
    int cnt;
    int delay;
    int exp_nwr;
    int exp_ovf;
    int exp_to;
    int exp_nout;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, o0, d0, r0, k;
    string p;

    for (int a = 0; a < 256; a++) ram[a] = ram_val(8'(a));

    //          n_in base  cnt delay nwr ovf to nout
    vecs[0] = '{3,   0,    2,  3,    3,  0,  0, 2};
    vecs[1] = '{1,   8'h40,1,  2,    1,  0,  0, 1};
    vecs[2] = '{25,  8'h10,3,  5,    20, 1,  0, 3};
    vecs[3] = '{2,   0,    0,  1,    2,  0,  0, 0};
    vecs[4] = '{4,   255,  3,  4,    4,  0,  0, 3};
    vecs[5] = '{2,   0,    5,  -1,   2,  0,  1, 0};
    vecs[6] = '{1,   3,    1,  0,    1,  0,  0, 1};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals("por");
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("por_idle_in_ready", in_ready, 1);
    check("por_idle_busy", busy, 0);

    for (int v = 0; v < 7; v++) begin
      p  = $sformatf("v%0d", v);
      w0 = wr_adr_q.size();
      o0 = out_q.size();
      d0 = done_tot;
      r0 = run_tot;
      load_words(vecs[v].n_in);
      start_accel(vecs[v].delay, vecs[v].base, vecs[v].cnt);
      wait_done(p, vecs[v].exp_ovf, vecs[v].exp_to);
      check({p, "_nwr"}, wr_adr_q.size() - w0, vecs[v].exp_nwr);
      for (int j = 0; j < vecs[v].exp_nwr && w0 + j < wr_adr_q.size(); j++) begin
        check($sformatf("%s_wadr%0d", p, j), wr_adr_q[w0+j], 20 + j);
        check($sformatf("%s_wdat%0d", p, j), wr_dat_q[w0+j], 5 + j);
        check($sformatf("%s_wrst%0d", p, j), wr_rst_q[w0+j], 1);
      end
      check({p, "_nout"}, out_q.size() - o0, vecs[v].exp_nout);
      for (int i = 0; i < vecs[v].exp_nout && o0 + i < out_q.size(); i++) begin
        check($sformatf("%s_odat%0d", p, i), out_q[o0+i], ram_val(8'(vecs[v].base + i)));
        check($sformatf("%s_olast%0d", p, i), outl_q[o0+i], (i == vecs[v].cnt - 1));
      end
      check({p, "_ndone"}, done_tot - d0, 1);
      if (vecs[v].exp_to != 0) check({p, "_run_cycles"}, run_tot - r0, TO);
    end

    // Output stall: word 0 held for 10 cycles with no read address advance.
    o0 = out_q.size();
    d0 = done_tot;
    out_ready = 1'b0;
    load_words(2);
    start_accel(1, 8'h30, 2);
    k = 0;
    while (!out_valid && k < 100) begin @(negedge clk); k++; end
    check("stall_vld_wait", out_valid, 1);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check($sformatf("stall_vld%0d", c), out_valid, 1);
      check($sformatf("stall_dat%0d", c), out_data, ram_val(8'h30));
      check($sformatf("stall_last%0d", c), out_last, 0);
      check($sformatf("stall_radr%0d", c), nr_read_adr, 8'h30);
    end
    out_ready = 1'b1;
    wait_done("stall", 0, 0);
    check("stall_nout", out_q.size() - o0, 2);
    if (out_q.size() - o0 == 2) begin
      check("stall_odat0", out_q[o0], ram_val(8'h30));
      check("stall_odat1", out_q[o0+1], ram_val(8'h31));
      check("stall_olast1", outl_q[o0+1], 1);
    end
    check("stall_ndone", done_tot - d0, 1);

    // Reset while a result is waiting in DRAIN_OUT.
    out_ready = 1'b0;
    load_words(1);
    start_accel(0, 5, 2);
    k = 0;
    while (!out_valid && k < 100) begin @(negedge clk); k++; end
    check("rst_vld_wait", out_valid, 1);
    w0 = wr_adr_q.size();
    o0 = out_q.size();
    d0 = done_tot;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_vals("midrst");
    accel_finished = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("midrst_nwr", wr_adr_q.size() - w0, 0);
    check("midrst_nout", out_q.size() - o0, 0);
    check("midrst_ndone", done_tot - d0, 0);
    check("midrst_busy", busy, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_accel_reset", accel_reset, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
